branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequencer between the execute-stage branch unit and the front end of the pipelined core. It takes each resolved control-transfer outcome and compares it with the static fetch-time prediction. On a mispredict it issues one registered PC redirect, then squashes the IF and ID stages for a fixed number of advancing cycles. It also keeps saturating branch and mispredict performance counters.

## Interface
Parameters:
- FLUSH_CYCLES, 2, number of advancing cycles IF/ID are squashed per mispredict, including the redirect cycle; legal range 1..7
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ex_valid_i  in  1  execute stage holds a valid instruction
- ex_is_branch_i  in  1  instruction is B-type
- ex_is_jump_i  in  1  instruction is JAL/JALR
- ex_pred_taken_i  in  1  static prediction made at fetch
- branch_taken_i  in  1  branch condition result from the branch unit (combinational)
- ex_pc_i  in  32  PC of the execute-stage instruction
- ex_target_i  in  32  computed branch/jump target
- stall_i  in  1  pipeline hold; execute stage does not advance
- redirect_valid_o  out  1  fetch must load redirect_pc_o
- redirect_pc_o  out  32  corrected fetch PC
- flush_if_o  out  1  squash IF stage
- flush_id_o  out  1  squash ID stage
- busy_o  out  1  controller is not IDLE
- branch_cnt_o  out  CNT_W  resolved control transfers
- mispredict_cnt_o  out  CNT_W  mispredicted control transfers

## Operation
- Resolve event: `ex_valid_i & (ex_is_branch_i | ex_is_jump_i) & !stall_i & state==IDLE`.
- Events while in REDIRECT/FLUSH are ignored. Those instructions are wrong-path and are squashed.
- actual_taken = `ex_is_jump_i | (ex_is_branch_i & branch_taken_i)`.
- mispredict = `actual_taken != ex_pred_taken_i`.
- If both is_branch and is_jump are set, jump wins.
- Redirect target:
  - actual_taken=1: ex_target_i
  - actual_taken=0: ex_pc_i + 4, modulo 2^32 (wraps 0xFFFFFFFC -> 0x00000000)
- States:
  - IDLE: all control outputs 0.
    - Resolve with mispredict -> REDIRECT; redirect_pc_o is registered and the flush counter is loaded with FLUSH_CYCLES-1.
    - Resolve without mispredict stays in IDLE.
  - REDIRECT: redirect_valid_o=1, flush_if_o=1, flush_id_o=1, busy_o=1.
    - Held while stall_i=1.
    - On !stall_i, goes to FLUSH if the counter is non-zero, else to IDLE.
  - FLUSH: flush_if_o=1, flush_id_o=1, busy_o=1, redirect_valid_o=0.
    - The counter decrements only on !stall_i.
    - On !stall_i with counter==1, goes to IDLE.
- Counters:
  - branch_cnt_o increments on every resolve event.
  - mispredict_cnt_o increments on resolve events with mispredict.
  - Both saturate at all-ones; they never wrap.
- redirect_pc_o holds its last value when redirect_valid_o=0.

## Timing
- All outputs are registered. Nothing is combinational from input to output.
- Reset values: state=IDLE; redirect_valid_o=0, redirect_pc_o=0, flush_if_o=0, flush_id_o=0, busy_o=0, both counters 0.
- A resolve event sampled at edge E has these effects:
  - redirect_valid_o, flush_*_o and busy_o are high from E until the next edge.
  - The counters show the increment after E.
- With stall_i=0 throughout, latency is as follows:
  - redirect is a one-cycle pulse;
  - flush is high for exactly FLUSH_CYCLES consecutive cycles;
  - IDLE is reached FLUSH_CYCLES cycles after E.
- stall_i in REDIRECT or FLUSH extends that state cycle-for-cycle. redirect_valid_o stays high until the first non-stalled cycle.
- The earliest next accepted resolve is sampled at the edge that returns to IDLE + 1 cycle. That is the first edge with state==IDLE.
- Reset asserted mid-sequence: at the next edge the state is IDLE and all outputs and counters are 0. Any pending redirect is dropped.
- Resolve with stall_i=1 is not an event. It is evaluated again when stall_i drops, provided the inputs are still held.

## Test plan
- Reset check: hold reset 3 cycles with random inputs -> all outputs 0, busy_o=0.
- BEQ, pred_taken=0, branch_taken=1, pc=0x100, target=0x80, FLUSH_CYCLES=2:
  - one cycle later redirect_valid_o=1, redirect_pc_o=0x80;
  - flush high for 2 cycles;
  - mispredict_cnt=1, branch_cnt=1.
- Branch predicted taken, not taken, pc=0xFFFFFFFC -> redirect_pc_o=0x00000000 (wrap). Correctly predicted branch -> no redirect, branch_cnt+1 only.
- Mispredict, then stall_i=1 for 3 cycles starting in the REDIRECT cycle:
  - redirect_valid_o stays high for 4 cycles;
  - flush total is 5 cycles;
  - a second mispredicting branch presented during flush is ignored (counters unchanged).
- Assert reset in the FLUSH cycle -> next cycle flush_*_o=0, busy_o=0, counters 0. The following branch resolves normally.
- Preload counters near saturation by driving 2^CNT_W mispredicts with CNT_W=4 -> both counters stop at 0xF.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: compares resolved control transfers with the
// fetch-time prediction, issues a registered redirect and squashes IF/ID.
module branch_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid_i,
    input  logic             ex_is_branch_i,
    input  logic             ex_is_jump_i,
    input  logic             ex_pred_taken_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      ex_pc_i,
    input  logic [31:0]      ex_target_i,
    input  logic             stall_i,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_if_o,
    output logic             flush_id_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [2:0]       FC_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic             flush_q, flush_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

    logic resolve;
    logic actual_taken;
    logic mispredict;

    // Resolve qualification; jump overrides the branch condition.
    always_comb begin
        actual_taken = ex_is_jump_i | (ex_is_branch_i & branch_taken_i);
        mispredict   = actual_taken != ex_pred_taken_i;
        resolve      = ex_valid_i & (ex_is_branch_i | ex_is_jump_i)
                     & ~stall_i & (state_q == IDLE);
    end

    // Next-state logic; outputs are derived from the next state so they
    // come straight out of flops.
    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            IDLE: begin
                if (resolve && mispredict) begin
                    state_d       = REDIRECT;
                    fcnt_d        = FC_LOAD;
                    redirect_pc_d = actual_taken ? ex_target_i
                                                 : ex_pc_i + 32'd4;
                end
            end
            REDIRECT: begin
                if (!stall_i) begin
                    state_d = (fcnt_q != 3'd0) ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                if (!stall_i) begin
                    if (fcnt_q <= 3'd1) begin
                        state_d = IDLE;
                        fcnt_d  = 3'd0;
                    end else begin
                        fcnt_d = fcnt_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = 3'd0;
            end
        endcase
        redirect_valid_d = (state_d == REDIRECT);
        flush_d          = (state_d != IDLE);
        busy_d           = (state_d != IDLE);
    end

    // Saturating performance counters.
    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (resolve && branch_cnt_q != CNT_MAX) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end
        if (resolve && mispredict && mispredict_cnt_q != CNT_MAX) begin
            mispredict_cnt_d = mispredict_cnt_q + 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            fcnt_q           <= 3'd0;
            redirect_pc_q    <= 32'd0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            busy_q           <= 1'b0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            state_q          <= state_d;
            fcnt_q           <= fcnt_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_valid_q <= redirect_valid_d;
            flush_q          <= flush_d;
            busy_q           <= busy_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign flush_if_o       = flush_q;
    assign flush_id_o       = flush_q;
    assign busy_o           = busy_q;
    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios plus
// random traffic, every cycle compared against a squash-budget model.
module tb_branch_redirect_ctrl;

    localparam int FC    = 2;
    localparam int CW    = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          ex_valid_i, ex_is_branch_i, ex_is_jump_i;
    logic          ex_pred_taken_i, branch_taken_i, stall_i;
    logic [31:0]   ex_pc_i, ex_target_i;
    logic          redirect_valid_o, flush_if_o, flush_id_o, busy_o;
    logic [31:0]   redirect_pc_o;
    logic [CW-1:0] branch_cnt_o, mispredict_cnt_o;

    int total = 0;
    int bad   = 0;

    // reference model: remaining squash cycles, pending redirect flag
    int          m_left;
    bit          m_redir;
    logic [31:0] m_pc;
    int          m_br, m_mp;

    branch_redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_valid_i       (ex_valid_i),
        .ex_is_branch_i   (ex_is_branch_i),
        .ex_is_jump_i     (ex_is_jump_i),
        .ex_pred_taken_i  (ex_pred_taken_i),
        .branch_taken_i   (branch_taken_i),
        .ex_pc_i          (ex_pc_i),
        .ex_target_i      (ex_target_i),
        .stall_i          (stall_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .flush_if_o       (flush_if_o),
        .flush_id_o       (flush_id_o),
        .busy_o           (busy_o),
        .branch_cnt_o     (branch_cnt_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit act;
        if (reset) begin
            m_left = 0; m_redir = 0; m_pc = 0; m_br = 0; m_mp = 0;
        end else if (m_left == 0) begin
            if (ex_valid_i && (ex_is_branch_i || ex_is_jump_i) && !stall_i) begin
                act = ex_is_jump_i || (ex_is_branch_i && branch_taken_i);
                if (m_br < MAXC) m_br++;
                if (act != ex_pred_taken_i) begin
                    if (m_mp < MAXC) m_mp++;
                    m_left  = FC;
                    m_redir = 1;
                    m_pc    = act ? ex_target_i : ex_pc_i + 32'd4;
                end
            end
        end else if (!stall_i) begin
            m_left--;
            m_redir = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("redirect_valid", 32'(redirect_valid_o), 32'(m_redir));
        chk("redirect_pc", redirect_pc_o, m_pc);
        chk("flush_if", 32'(flush_if_o), 32'(m_left > 0));
        chk("flush_id", 32'(flush_id_o), 32'(m_left > 0));
        chk("busy", 32'(busy_o), 32'(m_left > 0));
        chk("branch_cnt", 32'(branch_cnt_o), 32'(m_br));
        chk("mispredict_cnt", 32'(mispredict_cnt_o), 32'(m_mp));
    endtask

    task automatic idle_in();
        ex_valid_i = 0; ex_is_branch_i = 0; ex_is_jump_i = 0;
        ex_pred_taken_i = 0; branch_taken_i = 0; stall_i = 0;
    endtask

    task automatic br(input bit pred, input bit tk,
                      input logic [31:0] pc, input logic [31:0] tgt);
        ex_valid_i = 1; ex_is_branch_i = 1; ex_is_jump_i = 0;
        ex_pred_taken_i = pred; branch_taken_i = tk;
        ex_pc_i = pc; ex_target_i = tgt;
    endtask

    task automatic rand_in();
        ex_valid_i      = 1'($urandom);
        ex_is_branch_i  = 1'($urandom);
        ex_is_jump_i    = ($urandom_range(0, 3) == 0);
        ex_pred_taken_i = 1'($urandom);
        branch_taken_i  = 1'($urandom);
        stall_i         = ($urandom_range(0, 3) == 0);
        ex_pc_i         = $urandom & 32'hFFFF_FFFC;
        ex_target_i     = $urandom & 32'hFFFF_FFFC;
    endtask

    initial begin
        int fl;
        m_left = 0; m_redir = 0; m_pc = 0; m_br = 0; m_mp = 0;
        ex_pc_i = 0; ex_target_i = 0;
        idle_in();

        // reset with random inputs
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            rand_in();
            tick();
        end
        reset = 0;
        idle_in();
        tick();

        // BEQ mispredicted not-taken, actually taken
        br(0, 1, 32'h100, 32'h80);
        tick();
        idle_in();
        chk("beq_redirect_pulse", 32'(redirect_valid_o), 32'd1);
        chk("beq_redirect_pc", redirect_pc_o, 32'h80);
        fl = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (flush_if_o) fl++;
        end
        chk("beq_flush_len", 32'(fl), 32'(FC));
        chk("beq_mp_cnt", 32'(mispredict_cnt_o), 32'd1);
        chk("beq_br_cnt", 32'(branch_cnt_o), 32'd1);

        // predicted taken, not taken at top of address space
        br(1, 0, 32'hFFFF_FFFC, 32'h40);
        tick();
        idle_in();
        chk("wrap_pc", redirect_pc_o, 32'h0);
        tick(); tick();
        // correctly predicted branch
        br(1, 1, 32'h200, 32'h300);
        tick();
        idle_in();
        chk("correct_no_redirect", 32'(busy_o), 32'd0);
        tick();

        // mispredict, then stall 3 cycles from the redirect cycle
        br(0, 1, 32'h400, 32'h500);
        tick();
        idle_in();
        stall_i = 1;
        for (int i = 0; i < 3; i++) tick();
        chk("stall_redirect_held", 32'(redirect_valid_o), 32'd1);
        stall_i = 0;
        br(0, 1, 32'h600, 32'h700);
        tick();
        chk("wrong_path_ignored_mp", 32'(mispredict_cnt_o), 32'd3);
        idle_in();
        tick(); tick();

        // reset in the flush cycle
        br(0, 1, 32'h800, 32'h900);
        tick();
        idle_in();
        tick();
        chk("in_flush", 32'(flush_if_o), 32'd1);
        reset = 1;
        tick();
        reset = 0;
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_cnt", 32'(branch_cnt_o), 32'd0);
        br(0, 1, 32'hA00, 32'hB00);
        tick();
        idle_in();
        chk("post_reset_redirect", redirect_pc_o, 32'hB00);
        tick(); tick();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rand_in();
            reset = ($urandom_range(0, 49) == 0);
            tick();
        end
        reset = 0;
        idle_in();

        // saturation
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < MAXC + 5; i++) begin
            br(0, 1, 32'(i * 4), 32'h1000);
            tick();
            idle_in();
            tick(); tick();
        end
        chk("sat_br", 32'(branch_cnt_o), 32'(MAXC));
        chk("sat_mp", 32'(mispredict_cnt_o), 32'(MAXC));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
